// File: rtl/network_mul_arbiter_if.sv
// Handshake bundle between the requesters, the response consumer and the shared
// multiplier on one side and network_mul_arbiter on the other.
interface network_mul_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DIN_WIDTH  = 16,
  parameter int unsigned DOUT_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_a;
  logic [NUM_REQ*DIN_WIDTH-1:0] req_b;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_WIDTH-1:0]          rsp_id;
  logic [DOUT_WIDTH-1:0]        rsp_p;
  logic [DIN_WIDTH-1:0]         mul_din0;
  logic [DIN_WIDTH-1:0]         mul_din1;
  logic [DOUT_WIDTH-1:0]        mul_dout;

  // Environment side: requesters, response consumer and the multiplier itself
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_dout,
    input  req_ready, rsp_valid, rsp_id, rsp_p, mul_din0, mul_din1
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_dout,
    output req_ready, rsp_valid, rsp_id, rsp_p, mul_din0, mul_din1
  );
endinterface

// File: rtl/network_mul_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among NUM_REQ requesters,
// with an operand register (S1) feeding the multiplier and a registered response (S2).
module network_mul_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DIN_WIDTH  = 16,
  parameter int unsigned DOUT_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
) (
  input logic                ap_clk,
  input logic                ap_rst_n,
  network_mul_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (DOUT_WIDTH != 2 * DIN_WIDTH) begin : g_bad_width
    $error("DOUT_WIDTH must equal 2*DIN_WIDTH");
  end
  if ((1 << ID_WIDTH) < NUM_REQ) begin : g_bad_id
    $error("ID_WIDTH too narrow for NUM_REQ");
  end

  logic [IDX_W-1:0]      last;
  logic                  s1_valid;
  logic [ID_WIDTH-1:0]   s1_id;
  logic [DIN_WIDTH-1:0]  s1_a;
  logic [DIN_WIDTH-1:0]  s1_b;
  logic                  rsp_valid;
  logic [ID_WIDTH-1:0]   rsp_id;
  logic [DOUT_WIDTH-1:0] rsp_p;

  logic                  out_adv;
  logic                  s1_load;
  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      sel;
  logic                  hs;
  logic [NUM_REQ-1:0]    ready;

  logic [DIN_WIDTH-1:0]  a_arr [NUM_REQ];
  logic [DIN_WIDTH-1:0]  b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*DIN_WIDTH +: DIN_WIDTH];
    assign b_arr[g] = bus.req_b[g*DIN_WIDTH +: DIN_WIDTH];
  end

  assign out_adv = !rsp_valid || bus.rsp_ready;
  assign s1_load = !s1_valid || out_adv;

  // Search starts just after the last granted requester and wraps around
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sel         = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      sel = IDX_W'((32'(last) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[sel]) begin
        grant_found = 1'b1;
        grant_idx   = sel;
      end
    end
  end

  assign hs = s1_load && grant_found;

  always_comb begin
    ready = '0;
    if (hs) begin
      ready[grant_idx] = 1'b1;
    end
  end

  // S1 operand register and round-robin pointer
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
    end else if (s1_load) begin
      s1_valid <= grant_found;
      if (grant_found) begin
        s1_id <= ID_WIDTH'(grant_idx);
        s1_a  <= a_arr[grant_idx];
        s1_b  <= b_arr[grant_idx];
        last  <= grant_idx;
      end
    end
  end

  // S2 response register; product captured straight from the multiplier output
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else if (out_adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id <= s1_id;
        rsp_p  <= bus.mul_dout;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_p     = rsp_p;
  assign bus.mul_din0  = s1_a;
  assign bus.mul_din1  = s1_b;

endmodule

// File: tb/tb_network_mul_arbiter.sv
// Scoreboard bench for network_mul_arbiter: directed requests push expected
// (id, product) pairs; a negedge monitor pops and compares on each accepted response.
module tb_network_mul_arbiter;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;

  always #5 ap_clk = ~ap_clk;

  network_mul_arbiter_if #(.NUM_REQ(4), .DIN_WIDTH(16), .DOUT_WIDTH(32), .ID_WIDTH(2)) bus ();

  network_mul_arbiter #(.NUM_REQ(4), .DIN_WIDTH(16), .DOUT_WIDTH(32), .ID_WIDTH(2)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave)
  );

  // Stand-in for the shared combinational 16x16 multiplier
  assign bus.mul_dout = 32'(bus.mul_din0) * 32'(bus.mul_din1);

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] oh(input int g);
    logic [31:0] one;
    one = 32'd1;
    return one << g;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i] = v;
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask

  task automatic push(input int id, input logic [31:0] p);
    exp_t e;
    e.id = 2'(id);
    e.p  = p;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drain_and_check(input string name);
    repeat (5) step();
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every accepted response must match the head of the scoreboard
  always @(negedge ap_clk) begin
    if (ap_rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual id=%0d p=%h required none", bus.rsp_id, bus.rsp_p);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_p", bus.rsp_p, e.p);
      end
    end
  end

  logic [31:0] prod [4];
  int          g2 [8];
  int          g3 [6];
  int          g4 [5];

  initial begin
    prod[0] = 32'd2; prod[1] = 32'h100; prod[2] = 32'h1E208; prod[3] = 32'hFFFE0001;
    g2 = '{1, 2, 3, 0, 1, 2, 3, 0};
    g3 = '{1, 2, 3, 0, 1, 2};
    g4 = '{1, 3, 1, 1, 1};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();
    ap_rst_n = 1'b1;

    // Reset state
    @(negedge ap_clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_p", bus.rsp_p, 32'd0);
    chk("rst_din0", 32'(bus.mul_din0), 32'd0);
    chk("rst_din1", 32'(bus.mul_din1), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // Single request, two-cycle latency
    step();
    set_req(0, 1'b1, 16'd3, 16'd5);
    @(negedge ap_clk);
    chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    push(0, 32'd15);
    step();
    set_req(0, 1'b0, 16'd0, 16'd0);
    @(negedge ap_clk);
    chk("t1_valid_t1", 32'(bus.rsp_valid), 32'd0);
    chk("t1_din0", 32'(bus.mul_din0), 32'd3);
    chk("t1_din1", 32'(bus.mul_din1), 32'd5);
    @(negedge ap_clk);
    chk("t1_valid_t2", 32'(bus.rsp_valid), 32'd1);
    drain_and_check("t1_drain");

    // All four requesting continuously; pointer left at 0 by the previous grant
    set_req(0, 1'b1, 16'd1, 16'd2);
    set_req(1, 1'b1, 16'h10, 16'h10);
    set_req(2, 1'b1, 16'd1234, 16'd100);
    set_req(3, 1'b1, 16'hFFFF, 16'hFFFF);
    for (int k = 0; k < 8; k++) begin
      @(negedge ap_clk);
      chk("t2_grant", 32'(bus.req_ready), oh(g2[k]));
      if (k >= 2) chk("t2_rsp_every_cycle", 32'(bus.rsp_valid), 32'd1);
      push(g2[k], prod[g2[k]]);
      step();
    end
    bus.req_valid = '0;
    drain_and_check("t2_drain");

    // Backpressure for 5 cycles mid-stream
    bus.req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      chk("t3_grant_pre", 32'(bus.req_ready), oh(g3[k]));
      push(g3[k], prod[g3[k]]);
      step();
    end
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t3_hold_id", 32'(bus.rsp_id), 32'd2);
      chk("t3_hold_p", bus.rsp_p, 32'h1E208);
      chk("t3_stall_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    for (int k = 3; k < 6; k++) begin
      @(negedge ap_clk);
      chk("t3_grant_post", 32'(bus.req_ready), oh(g3[k]));
      push(g3[k], prod[g3[k]]);
      step();
    end
    bus.req_valid = '0;
    drain_and_check("t3_drain");

    // Requesters 1 and 3 only, from a fresh pointer
    ap_rst_n = 1'b0;
    repeat (2) step();
    ap_rst_n = 1'b1;
    set_req(1, 1'b1, 16'd7, 16'd9);
    set_req(3, 1'b1, 16'h100, 16'h100);
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      chk("t4_grant", 32'(bus.req_ready), oh(g4[k]));
      push(g4[k], (g4[k] == 1) ? 32'd63 : 32'h10000);
      step();
      if (k == 1) set_req(3, 1'b0, 16'd0, 16'd0);
    end
    bus.req_valid = '0;
    drain_and_check("t4_drain");

    // Asynchronous reset with two products in flight
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 16'd2, 16'd7);
    set_req(1, 1'b1, 16'd5, 16'd5);
    @(negedge ap_clk);
    chk("t5_grant0", 32'(bus.req_ready), 32'h1);
    step();
    @(negedge ap_clk);
    chk("t5_grant1", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = '0;
    @(negedge ap_clk);
    chk("t5_inflight_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t5_inflight_p", bus.rsp_p, 32'd14);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_async_din0", 32'(bus.mul_din0), 32'd0);
    @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ap_clk);
      chk("t5_no_stale", 32'(bus.rsp_valid), 32'd0);
    end

    // First grant after reset goes to 0; zero operand; idle gap
    step();
    set_req(0, 1'b1, 16'd0, 16'hFFFF);
    set_req(1, 1'b1, 16'd1, 16'd1);
    set_req(2, 1'b1, 16'd1, 16'd1);
    set_req(3, 1'b1, 16'd1, 16'd1);
    @(negedge ap_clk);
    chk("t6_first_grant", 32'(bus.req_ready), 32'h1);
    push(0, 32'd0);
    step();
    bus.req_valid = '0;
    @(negedge ap_clk);
    chk("t6_valid_t1", 32'(bus.rsp_valid), 32'd0);
    @(negedge ap_clk);
    chk("t6_valid_t2", 32'(bus.rsp_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      chk("t6_gap", 32'(bus.rsp_valid), 32'd0);
    end
    step();
    set_req(2, 1'b1, 16'h8000, 16'd2);
    @(negedge ap_clk);
    chk("t6_grant2", 32'(bus.req_ready), 32'h4);
    push(2, 32'h10000);
    step();
    bus.req_valid = '0;
    drain_and_check("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/network_mul_arbiter.md
Name: network_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 16x16 unsigned multiplier (network_mul_mul_16ns_16ns_32_1_1) among NUM_REQ requesters in the network datapath.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier from an operand register.
- Returns each 32-bit product, tagged with the requester index, through a registered valid/ready response port.
- Sustains one product per cycle when the response port is not stalled.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIN_WIDTH, 16, operand width; must match the multiplier's din0/din1 width.
- DOUT_WIDTH, 32, product width; must equal 2*DIN_WIDTH.
- ID_WIDTH, 2, width of rsp_id; must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- ap_clk  in  1  clock; all registers on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  bit i: requester i presents operands.
- req_ready  out  NUM_REQ  bit i: requester i's operands are accepted this cycle.
- req_a  in  NUM_REQ*DIN_WIDTH  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*DIN_WIDTH  operand B; slice i belongs to requester i.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_id  out  ID_WIDTH  requester index of the product.
- rsp_p  out  DOUT_WIDTH  unsigned product.
- mul_din0  out  DIN_WIDTH  to multiplier din0.
- mul_din1  out  DIN_WIDTH  to multiplier din1.
- mul_dout  in  DOUT_WIDTH  from multiplier dout (combinational).

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_p=0.
  - s1_valid=0, s1_id=0, s1_a=0, s1_b=0, so mul_din0=mul_din1=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
  - Reset mid-operation discards all in-flight products; nothing is replayed.
- Two-stage pipeline:
  - S1 operand register (s1_valid, s1_id, s1_a, s1_b); mul_din0=s1_a and mul_din1=s1_b directly from registers.
  - S2 output register (rsp_valid, rsp_id, rsp_p).
- Control equations (combinational):
  - out_adv = !rsp_valid | rsp_ready
  - s1_adv = s1_valid & out_adv
  - s1_load = !s1_valid | s1_adv
- Arbitration (combinational):
  - Search requesters last+1, last+2, ... modulo NUM_REQ; grant the first with req_valid=1.
  - req_ready = one-hot(grant) when s1_load=1 and any req_valid; otherwise all zero.
  - req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Handshake at a clock edge with req_valid[g] & req_ready[g]:
  - S1 <= {1, g, req_a[g], req_b[g]}.
  - last <= g.
- S1 without a handshake:
  - If s1_load is high and no request is granted, s1_valid <= 0.
  - If s1_load is low, S1 holds.
- S2:
  - If out_adv=1: rsp_valid <= s1_valid; when s1_valid=1, rsp_p <= mul_dout and rsp_id <= s1_id.
  - If out_adv=0: S2 holds and rsp_p stays stable.
- Latency and throughput:
  - Request handshake in cycle T gives rsp_valid=1 in cycle T+2 if rsp_ready was not low at the T+1 edge.
  - Throughput is 1 per cycle.
- Ordering: responses leave in grant order; no reordering.
- Backpressure, rsp_ready=0 with rsp_valid=1:
  - S2 holds and S1 holds if valid.
  - All req_ready=0 when S1 is full; at most 2 products are in flight.
- Simultaneous events:
  - Response drain and new grant in the same cycle are both allowed (full throughput).
  - A requester keeping req_valid high is granted at most once per NUM_REQ grants while others are requesting (fairness).
- A single active requester is granted every cycle.
- Arithmetic: unsigned, full DOUT_WIDTH product, no truncation or saturation. The block performs no arithmetic itself.
- Requester must hold req_a/req_b stable while req_valid=1 and req_ready=0.

Test Plan:
- Reset then single request (req0: a=3, b=5) -> req_ready[0]=1 in the same cycle; rsp_valid=1 two cycles later with rsp_id=0, rsp_p=15.
- All four requesters valid continuously, rsp_ready=1:
  - grants follow 0,1,2,3,0,...;
  - one response per cycle;
  - products match each requester's operands (e.g. 0xFFFF*0xFFFF = 0xFFFE0001 on req3).
- rsp_ready=0 for 5 cycles mid-stream:
  - rsp_valid, rsp_p and rsp_id hold;
  - req_ready=0 after S1 fills;
  - on release, no product is lost or duplicated; order is preserved.
- Requesters 1 and 3 only; req3 drops after its first grant:
  - grants are 1,3,1,1,1;
  - idle requesters are never granted.
- Assert ap_rst_n low asynchronously (mid-cycle) with 2 products in flight:
  - rsp_valid falls immediately;
  - after release, no stale product is emitted;
  - the first grant goes to requester 0.
- Zero operands (a=0, b=0xFFFF) and an idle gap between requests -> rsp_p=0; rsp_valid is low during the gap.
